// File: rtl/serdes_link_arbiter_if.sv
// Bundle of requester, serdes and status signals around serdes_link_arbiter.
// master = the arbiter itself, slave = requesters, serdes and observers.
interface serdes_link_arbiter_if #(
  parameter int NUM_REQ    = 4,
  parameter int DATA_WIDTH = 8,
  parameter int CHAN_W     = $clog2(NUM_REQ)
);
  // Requester side: payload words, one lane per channel
  logic [NUM_REQ*DATA_WIDTH-1:0] req_data_i;
  logic [NUM_REQ-1:0]            req_valid_i;
  logic [NUM_REQ-1:0]            req_last_i;
  logic [NUM_REQ-1:0]            req_ready_o;

  // Serdes parallel side
  logic [DATA_WIDTH-1:0]         ser_data_o;
  logic                          ser_valid_o;
  logic                          ser_ready_i;

  // Status
  logic [NUM_REQ-1:0]            grant_o;
  logic [CHAN_W-1:0]             active_chan_o;
  logic                          burst_trunc_o;
  logic [1:0]                    dbg_state_o;

  modport master (
    input  req_data_i, req_valid_i, req_last_i, ser_ready_i,
    output req_ready_o, ser_data_o, ser_valid_o,
    output grant_o, active_chan_o, burst_trunc_o, dbg_state_o
  );

  modport slave (
    output req_data_i, req_valid_i, req_last_i, ser_ready_i,
    input  req_ready_o, ser_data_o, ser_valid_o,
    input  grant_o, active_chan_o, burst_trunc_o, dbg_state_o
  );
endinterface

// File: rtl/serdes_link_arbiter.sv
// Round-robin scheduler sharing one serdes TX parallel input among NUM_REQ
// requesters. Each grant sends a header word (MSB set, channel index in the
// low bits) followed by up to MAX_BURST payload words from the winner.
//
// Handshake: on every valid/ready pair a word moves when both are high at a
// rising clk_i. A source holds valid and data stable from the cycle it raises
// valid until the word is accepted; ready may toggle freely.
module serdes_link_arbiter #(
  parameter int NUM_REQ    = 4,
  parameter int DATA_WIDTH = 8,
  parameter int MAX_BURST  = 8,
  parameter int CHAN_W     = $clog2(NUM_REQ)
) (
  input  logic            clk_i,
  input  logic            rst_i,
  serdes_link_arbiter_if.master bus
);

  localparam int BEAT_W = (MAX_BURST > 1) ? $clog2(MAX_BURST) : 1;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    HEADER = 2'd1,
    BURST  = 2'd2
  } state_t;

  state_t              state_q, state_d;
  logic [NUM_REQ-1:0]  grant_q, grant_d;
  logic [CHAN_W-1:0]   chan_q,  chan_d;
  logic [CHAN_W-1:0]   rr_q,    rr_d;
  logic [BEAT_W-1:0]   beat_q,  beat_d;

  // Arbitration results
  logic                arb_found;
  logic [CHAN_W-1:0]   arb_sel;
  logic [NUM_REQ-1:0]  arb_onehot;
  logic [CHAN_W-1:0]   cand;

  // Granted requester lane
  logic                  g_valid;
  logic                  g_last;
  logic [DATA_WIDTH-1:0] g_data;
  logic                  beat_at_max;

  // Output drivers
  logic [DATA_WIDTH-1:0] header_word;
  logic [DATA_WIDTH-1:0] ser_data;
  logic                  ser_valid;
  logic [NUM_REQ-1:0]    req_ready;
  logic                  trunc;

  // Round-robin search: first valid requester starting just after rr_q
  always_comb begin
    arb_found  = 1'b0;
    arb_sel    = '0;
    arb_onehot = '0;
    cand       = '0;
    for (int i = 1; i <= NUM_REQ; i++) begin
      cand = CHAN_W'((int'(rr_q) + i) % NUM_REQ);
      if (!arb_found && bus.req_valid_i[cand]) begin
        arb_found = 1'b1;
        arb_sel   = cand;
      end
    end
    arb_onehot[arb_sel] = arb_found;
  end

  // Select the granted requester's lane
  always_comb begin
    g_valid = 1'b0;
    g_last  = 1'b0;
    g_data  = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      if (chan_q == CHAN_W'(k)) begin
        g_valid = bus.req_valid_i[k];
        g_last  = bus.req_last_i[k];
        g_data  = bus.req_data_i[k*DATA_WIDTH +: DATA_WIDTH];
      end
    end
  end

  // Header word: MSB marks the frame start, channel index in the low bits
  always_comb begin
    header_word                 = '0;
    header_word[DATA_WIDTH-1]   = 1'b1;
    header_word[CHAN_W-1:0]     = chan_q;
  end

  assign beat_at_max = (beat_q == BEAT_W'(MAX_BURST - 1));

  // Next-state and output decode
  always_comb begin
    state_d   = state_q;
    grant_d   = grant_q;
    chan_d    = chan_q;
    rr_d      = rr_q;
    beat_d    = beat_q;
    ser_valid = 1'b0;
    ser_data  = '0;
    req_ready = '0;
    trunc     = 1'b0;

    case (state_q)
      IDLE: begin
        if (arb_found) begin
          state_d = HEADER;
          grant_d = arb_onehot;
          chan_d  = arb_sel;
        end
      end

      HEADER: begin
        ser_valid = 1'b1;
        ser_data  = header_word;
        if (bus.ser_ready_i) begin
          beat_d  = '0;
          state_d = BURST;
        end
      end

      BURST: begin
        ser_valid = g_valid;
        ser_data  = g_data;
        req_ready = grant_q & {NUM_REQ{bus.ser_ready_i}};
        if (g_valid && bus.ser_ready_i) begin
          if (g_last || beat_at_max) begin
            // Burst over: the served channel drops to lowest priority
            state_d = IDLE;
            rr_d    = chan_q;
            grant_d = '0;
            chan_d  = '0;
            trunc   = !g_last && beat_at_max;
          end else begin
            beat_d = beat_q + 1'b1;
          end
        end
      end

      default: begin
        state_d = IDLE;
        grant_d = '0;
        chan_d  = '0;
      end
    endcase
  end

  // State register; reset abandons any burst in flight
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= IDLE;
      grant_q <= '0;
      chan_q  <= '0;
      rr_q    <= CHAN_W'(NUM_REQ - 1);
      beat_q  <= '0;
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      chan_q  <= chan_d;
      rr_q    <= rr_d;
      beat_q  <= beat_d;
    end
  end

  assign bus.ser_data_o    = ser_data;
  assign bus.ser_valid_o   = ser_valid;
  assign bus.req_ready_o   = req_ready;
  assign bus.grant_o       = grant_q;
  assign bus.active_chan_o = chan_q;
  assign bus.burst_trunc_o = trunc;
  assign bus.dbg_state_o   = state_q;

  // At most one channel is ever granted
  a_grant_onehot: assert property (@(posedge clk_i) disable iff (rst_i) $onehot0(grant_q));

endmodule

// File: tb/tb_serdes_link_arbiter.sv
// Directed bench for serdes_link_arbiter: per-channel source model, serdes
// sink with scripted ready, and per-scenario checks against hand-built lists.
module tb_serdes_link_arbiter;
  localparam int N   = 4;
  localparam int DW  = 8;
  localparam int MB  = 8;
  localparam int CW  = 2;
  localparam int NDW = N * DW;

  logic clk_i = 1'b0;
  logic rst_i = 1'b1;

  // Clock/reset block
  always #5 clk_i = ~clk_i;

  serdes_link_arbiter_if #(.NUM_REQ(N), .DATA_WIDTH(DW)) bus ();

  serdes_link_arbiter #(
    .NUM_REQ(N), .DATA_WIDTH(DW), .MAX_BURST(MB)
  ) dut (
    .clk_i (clk_i),
    .rst_i (rst_i),
    .bus   (bus)
  );

  // Source model: per-channel word lists
  logic [DW-1:0] src_data [N][32];
  logic          src_last [N][32];
  int            src_len  [N];
  int            src_pos  [N];
  int            gap_at   [N];
  int            gap_len  [N];
  int            gap_cnt  [N];

  // Sink model and scoreboard
  logic          ready_toggle;
  logic          ser_ready_v;
  logic [DW-1:0] got_q[$];
  logic [DW-1:0] exp_q[$];
  int            hdr_cyc_q[$];
  int            trunc_idx_q[$];
  int            payload_cnt, trunc_cnt, ready0_cnt, stab_err, stall_cnt, cyc;
  logic          prev_v, prev_r;
  logic [DW-1:0] prev_d;

  int checks   = 0;
  int failures = 0;

  task automatic clear_model();
    for (int k = 0; k < N; k++) begin
      src_len[k] = 0; src_pos[k] = 0;
      gap_at[k]  = 0; gap_len[k] = 0; gap_cnt[k] = 0;
    end
    got_q.delete(); exp_q.delete(); hdr_cyc_q.delete(); trunc_idx_q.delete();
    payload_cnt = 0; trunc_cnt = 0; ready0_cnt = 0; stab_err = 0; stall_cnt = 0; cyc = 0;
    prev_v = 1'b0; prev_r = 1'b0; prev_d = '0;
    ready_toggle = 1'b0; ser_ready_v = 1'b1;
    bus.req_data_i  = '0;
    bus.req_valid_i = '0;
    bus.req_last_i  = '0;
    bus.ser_ready_i = 1'b1;
  endtask

  task automatic apply_reset();
    @(negedge clk_i);
    rst_i = 1'b1;
    clear_model();
    repeat (2) @(negedge clk_i);
    rst_i = 1'b0;
  endtask

  // One message of n words on channel ch, data base+i, last on the final word
  task automatic load(input int ch, input int n, input logic [DW-1:0] base, input bit with_last);
    for (int i = 0; i < n; i++) begin
      src_data[ch][i] = base + DW'(i);
      src_last[ch][i] = with_last && (i == n - 1);
    end
    src_len[ch] = n;
    src_pos[ch] = 0;
  endtask

  // Driver: one clock of stimulus, then observe outputs before the next edge
  task automatic step();
    logic [NDW-1:0] dvec;
    logic [N-1:0]   vvec, lvec;
    logic [CW-1:0]  ch;
    @(negedge clk_i);
    dvec = '0; vvec = '0; lvec = '0;
    for (int k = 0; k < N; k++) begin
      if (gap_cnt[k] > 0) begin
        gap_cnt[k]--;
      end else if (src_pos[k] < src_len[k]) begin
        dvec = dvec | (NDW'(src_data[k][src_pos[k]]) << (k * DW));
        vvec = vvec | (N'(1) << k);
        if (src_last[k][src_pos[k]]) lvec = lvec | (N'(1) << k);
      end
    end
    bus.req_data_i  = dvec;
    bus.req_valid_i = vvec;
    bus.req_last_i  = lvec;
    if (ready_toggle) ser_ready_v = ~ser_ready_v;
    bus.ser_ready_i = ser_ready_v;
    #1;
    if (prev_v && !prev_r && (!bus.ser_valid_o || bus.ser_data_o !== prev_d)) stab_err++;
    if (bus.ser_valid_o && !bus.ser_ready_i) stall_cnt++;
    if (bus.burst_trunc_o) trunc_cnt++;
    if (bus.ser_valid_o && bus.ser_ready_i) begin
      got_q.push_back(bus.ser_data_o);
      if (bus.ser_data_o[DW-1]) begin
        hdr_cyc_q.push_back(cyc);
      end else begin
        payload_cnt++;
        if (bus.burst_trunc_o) trunc_idx_q.push_back(payload_cnt);
      end
    end
    if (bus.req_ready_o[0]) ready0_cnt++;
    for (int k = 0; k < N; k++) begin
      ch = CW'(k);
      if (bus.req_valid_i[ch] && bus.req_ready_o[ch]) begin
        src_pos[k]++;
        if (gap_len[k] > 0 && src_pos[k] == gap_at[k]) gap_cnt[k] = gap_len[k];
      end
    end
    prev_v = bus.ser_valid_o;
    prev_r = bus.ser_ready_i;
    prev_d = bus.ser_data_o;
    cyc++;
  endtask

  // Step until every source is drained and the arbiter is back in IDLE
  task automatic run_until_done(input int budget, output bit ok);
    bit drained;
    ok = 1'b0;
    for (int c = 0; c < budget; c++) begin
      step();
      drained = 1'b1;
      for (int k = 0; k < N; k++) if (src_pos[k] < src_len[k] || gap_cnt[k] > 0) drained = 1'b0;
      if (drained && bus.grant_o == '0 && !bus.ser_valid_o) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic test_reset();
    rst_i = 1'b1;
    clear_model();
    repeat (2) @(negedge clk_i);
    #1;
    checks++; if (bus.grant_o !== 4'b0000) begin failures++; $display("FAIL reset_grant got=%b exp=0000", bus.grant_o); end
    checks++; if (bus.ser_valid_o !== 1'b0) begin failures++; $display("FAIL reset_ser_valid got=%b exp=0", bus.ser_valid_o); end
    checks++; if (bus.req_ready_o !== 4'b0000) begin failures++; $display("FAIL reset_req_ready got=%b exp=0000", bus.req_ready_o); end
    checks++; if (bus.active_chan_o !== 2'd0) begin failures++; $display("FAIL reset_active_chan got=%0d exp=0", bus.active_chan_o); end
    checks++; if (bus.burst_trunc_o !== 1'b0) begin failures++; $display("FAIL reset_trunc got=%b exp=0", bus.burst_trunc_o); end
    checks++; if (bus.dbg_state_o !== 2'd0) begin failures++; $display("FAIL reset_state got=%0d exp=0", bus.dbg_state_o); end
    @(negedge clk_i);
    rst_i = 1'b0;
    step();
    checks++; if (bus.ser_valid_o !== 1'b0 || bus.grant_o !== 4'b0000) begin
      failures++; $display("FAIL idle_no_req got valid=%b grant=%b exp valid=0 grant=0000", bus.ser_valid_o, bus.grant_o);
    end
  endtask

  task automatic test_single_burst();
    bit ok;
    apply_reset();
    src_data[0][0] = 8'h11; src_last[0][0] = 1'b0;
    src_data[0][1] = 8'h22; src_last[0][1] = 1'b0;
    src_data[0][2] = 8'h33; src_last[0][2] = 1'b1;
    src_len[0] = 3;
    exp_q = '{8'h80, 8'h11, 8'h22, 8'h33};
    run_until_done(30, ok);
    checks++; if (!ok) begin failures++; $display("FAIL single_timeout got=not_done exp=done"); end
    checks++; if (got_q.size() !== exp_q.size()) begin failures++; $display("FAIL single_len got=%0d exp=%0d", got_q.size(), exp_q.size()); end
    for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
      checks++; if (got_q[i] !== exp_q[i]) begin failures++; $display("FAIL single_word[%0d] got=%h exp=%h", i, got_q[i], exp_q[i]); end
    end
    checks++; if (ready0_cnt !== 3) begin failures++; $display("FAIL single_ready0_cycles got=%0d exp=3", ready0_cnt); end
    checks++; if (bus.grant_o !== 4'b0000 || bus.active_chan_o !== 2'd0) begin
      failures++; $display("FAIL single_end_idle got grant=%b chan=%0d exp grant=0000 chan=0", bus.grant_o, bus.active_chan_o);
    end
  endtask

  task automatic test_round_robin();
    bit ok;
    apply_reset();
    for (int k = 0; k < N; k++) begin
      src_data[k][0] = 8'h10 + DW'(k); src_last[k][0] = 1'b1;
      src_data[k][1] = 8'h20 + DW'(k); src_last[k][1] = 1'b1;
      src_len[k] = 2;
    end
    exp_q = '{8'h80, 8'h10, 8'h81, 8'h11, 8'h82, 8'h12, 8'h83, 8'h13,
              8'h80, 8'h20, 8'h81, 8'h21, 8'h82, 8'h22, 8'h83, 8'h23};
    run_until_done(80, ok);
    checks++; if (!ok) begin failures++; $display("FAIL rr_timeout got=not_done exp=done"); end
    checks++; if (got_q.size() !== exp_q.size()) begin failures++; $display("FAIL rr_len got=%0d exp=%0d", got_q.size(), exp_q.size()); end
    for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
      checks++; if (got_q[i] !== exp_q[i]) begin failures++; $display("FAIL rr_word[%0d] got=%h exp=%h", i, got_q[i], exp_q[i]); end
    end
    // header, payload, IDLE bubble, next header
    for (int i = 1; i < hdr_cyc_q.size(); i++) begin
      checks++; if (hdr_cyc_q[i] - hdr_cyc_q[i-1] !== 3) begin
        failures++; $display("FAIL rr_header_spacing[%0d] got=%0d exp=3", i, hdr_cyc_q[i] - hdr_cyc_q[i-1]);
      end
    end
  endtask

  task automatic test_truncation();
    bit ok;
    apply_reset();
    // 20 words, only the final one carries last so the message can close
    load(2, 20, 8'h00, 1'b1);
    exp_q.push_back(8'h82);
    for (int i = 0; i < 8; i++)   exp_q.push_back(DW'(i));
    exp_q.push_back(8'h82);
    for (int i = 8; i < 16; i++)  exp_q.push_back(DW'(i));
    exp_q.push_back(8'h82);
    for (int i = 16; i < 20; i++) exp_q.push_back(DW'(i));
    run_until_done(80, ok);
    checks++; if (!ok) begin failures++; $display("FAIL trunc_timeout got=not_done exp=done"); end
    checks++; if (got_q.size() !== exp_q.size()) begin failures++; $display("FAIL trunc_len got=%0d exp=%0d", got_q.size(), exp_q.size()); end
    for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
      checks++; if (got_q[i] !== exp_q[i]) begin failures++; $display("FAIL trunc_word[%0d] got=%h exp=%h", i, got_q[i], exp_q[i]); end
    end
    checks++; if (trunc_cnt !== 2) begin failures++; $display("FAIL trunc_pulses got=%0d exp=2", trunc_cnt); end
    checks++; if (trunc_idx_q.size() !== 2) begin
      failures++; $display("FAIL trunc_positions got=%0d entries exp=2", trunc_idx_q.size());
    end else begin
      checks++; if (trunc_idx_q[0] !== 8 || trunc_idx_q[1] !== 16) begin
        failures++; $display("FAIL trunc_positions got=%0d,%0d exp=8,16", trunc_idx_q[0], trunc_idx_q[1]);
      end
    end

    // last arriving exactly on the MAX_BURST-th word is a normal end
    apply_reset();
    load(1, MB, 8'h40, 1'b1);
    exp_q = '{8'h81, 8'h40, 8'h41, 8'h42, 8'h43, 8'h44, 8'h45, 8'h46, 8'h47};
    run_until_done(40, ok);
    checks++; if (!ok) begin failures++; $display("FAIL last_at_max_timeout got=not_done exp=done"); end
    checks++; if (got_q.size() !== exp_q.size()) begin failures++; $display("FAIL last_at_max_len got=%0d exp=%0d", got_q.size(), exp_q.size()); end
    for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
      checks++; if (got_q[i] !== exp_q[i]) begin failures++; $display("FAIL last_at_max_word[%0d] got=%h exp=%h", i, got_q[i], exp_q[i]); end
    end
    checks++; if (trunc_cnt !== 0) begin failures++; $display("FAIL last_at_max_trunc got=%0d exp=0", trunc_cnt); end
  endtask

  task automatic test_ready_toggle();
    bit ok;
    apply_reset();
    load(3, 4, 8'h50, 1'b1);
    ready_toggle = 1'b1;
    ser_ready_v  = 1'b0;
    exp_q = '{8'h83, 8'h50, 8'h51, 8'h52, 8'h53};
    run_until_done(40, ok);
    checks++; if (!ok) begin failures++; $display("FAIL toggle_timeout got=not_done exp=done"); end
    checks++; if (got_q.size() !== exp_q.size()) begin failures++; $display("FAIL toggle_len got=%0d exp=%0d", got_q.size(), exp_q.size()); end
    for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
      checks++; if (got_q[i] !== exp_q[i]) begin failures++; $display("FAIL toggle_word[%0d] got=%h exp=%h", i, got_q[i], exp_q[i]); end
    end
    checks++; if (stab_err !== 0) begin failures++; $display("FAIL toggle_stability got=%0d exp=0", stab_err); end
    // header held once, then each of the four payload words waits one cycle
    checks++; if (stall_cnt !== 5) begin failures++; $display("FAIL toggle_stalls got=%0d exp=5", stall_cnt); end
  endtask

  task automatic test_valid_stall();
    bit ok;
    apply_reset();
    load(0, 6, 8'h60, 1'b1);
    gap_at[0] = 2; gap_len[0] = 5;
    load(1, 1, 8'h70, 1'b1);
    exp_q = '{8'h80, 8'h60, 8'h61, 8'h62, 8'h63, 8'h64, 8'h65, 8'h81, 8'h70};
    for (int c = 0; c < 20 && src_pos[0] < 2; c++) step();
    checks++; if (src_pos[0] !== 2) begin failures++; $display("FAIL stall_reach got=%0d words exp=2", src_pos[0]); end
    for (int c = 0; c < 5; c++) begin
      step();
      checks++; if (bus.grant_o !== 4'b0001 || bus.ser_valid_o !== 1'b0) begin
        failures++; $display("FAIL stall_hold[%0d] got grant=%b valid=%b exp grant=0001 valid=0", c, bus.grant_o, bus.ser_valid_o);
      end
    end
    run_until_done(40, ok);
    checks++; if (!ok) begin failures++; $display("FAIL stall_timeout got=not_done exp=done"); end
    checks++; if (got_q.size() !== exp_q.size()) begin failures++; $display("FAIL stall_len got=%0d exp=%0d", got_q.size(), exp_q.size()); end
    for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
      checks++; if (got_q[i] !== exp_q[i]) begin failures++; $display("FAIL stall_word[%0d] got=%h exp=%h", i, got_q[i], exp_q[i]); end
    end
  endtask

  task automatic test_async_reset();
    bit ok;
    apply_reset();
    // serve channel 2 first so rr no longer sits at its reset value
    load(2, 1, 8'h05, 1'b1);
    run_until_done(20, ok);
    checks++; if (!ok || got_q.size() !== 2) begin failures++; $display("FAIL areset_pre got=%0d words exp=2", got_q.size()); end
    load(1, 6, 8'h30, 1'b1);
    repeat (4) step();
    checks++; if (bus.grant_o !== 4'b0010) begin failures++; $display("FAIL areset_midburst_grant got=%b exp=0010", bus.grant_o); end
    #2;
    rst_i = 1'b1;
    #1;
    checks++; if (bus.grant_o !== 4'b0000) begin failures++; $display("FAIL areset_grant got=%b exp=0000", bus.grant_o); end
    checks++; if (bus.active_chan_o !== 2'd0) begin failures++; $display("FAIL areset_chan got=%0d exp=0", bus.active_chan_o); end
    checks++; if (bus.ser_valid_o !== 1'b0) begin failures++; $display("FAIL areset_valid got=%b exp=0", bus.ser_valid_o); end
    checks++; if (bus.req_ready_o !== 4'b0000) begin failures++; $display("FAIL areset_ready got=%b exp=0000", bus.req_ready_o); end
    checks++; if (bus.dbg_state_o !== 2'd0) begin failures++; $display("FAIL areset_state got=%0d exp=0", bus.dbg_state_o); end
    clear_model();
    repeat (2) @(negedge clk_i);
    rst_i = 1'b0;
    load(0, 1, 8'h0A, 1'b1);
    load(3, 1, 8'h0D, 1'b1);
    exp_q = '{8'h80, 8'h0A, 8'h83, 8'h0D};
    run_until_done(30, ok);
    checks++; if (!ok) begin failures++; $display("FAIL areset_post_timeout got=not_done exp=done"); end
    checks++; if (got_q.size() !== exp_q.size()) begin failures++; $display("FAIL areset_post_len got=%0d exp=%0d", got_q.size(), exp_q.size()); end
    for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
      checks++; if (got_q[i] !== exp_q[i]) begin failures++; $display("FAIL areset_post_word[%0d] got=%h exp=%h", i, got_q[i], exp_q[i]); end
    end
  endtask

  initial begin
    test_reset();
    test_single_burst();
    test_round_robin();
    test_truncation();
    test_ready_toggle();
    test_valid_stall();
    test_async_reset();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/serdes_link_arbiter.md
Name: serdes_link_arbiter

Overview:
- Round-robin scheduler that shares one serdes TX parallel input among NUM_REQ requesters.
- Each granted burst is framed with a header word carrying the channel index, followed by the requester's payload words.
- A burst ends on the requester's last flag or when MAX_BURST payload words have been sent, whichever comes first.
- Sits directly in front of the serdes parallel_in/valid_in/ready_out interface.

Parameters:
- NUM_REQ, 4, number of requesters (2..16)
- DATA_WIDTH, 8, payload and serdes word width; must be >= CHAN_W+1
- MAX_BURST, 8, maximum payload words per grant (>=1)
- CHAN_W, $clog2(NUM_REQ), derived; channel index width

Ports:
- clk_i  input  1  clock
- rst_i  input  1  asynchronous, active-high reset
- req_data_i  input  NUM_REQ*DATA_WIDTH  requester payload; channel k occupies bits [k*DATA_WIDTH +: DATA_WIDTH]
- req_valid_i  input  NUM_REQ  per-requester word valid
- req_last_i  input  NUM_REQ  per-requester end-of-message, qualified by valid
- req_ready_o  output  NUM_REQ  per-requester word accepted when valid&ready
- ser_data_o  output  DATA_WIDTH  to serdes parallel_in
- ser_valid_o  output  1  to serdes valid_in
- ser_ready_i  input  1  from serdes ready_out
- grant_o  output  NUM_REQ  one-hot current grant; zero in IDLE
- active_chan_o  output  CHAN_W  index of granted channel; 0 in IDLE
- burst_trunc_o  output  1  one-cycle pulse when a burst ends by MAX_BURST without last

Behaviour:
- Reset values:
  - state=IDLE, grant_o=0, active_chan_o=0, rr pointer=NUM_REQ-1.
  - ser_valid_o=0, req_ready_o=0, burst_trunc_o=0, beat counter=0.
  - Reset is asynchronous and may occur mid-burst. The state returns to IDLE immediately with no flush. Any partially sent burst is abandoned; downstream resynchronises on the next header.
- Transfer rule: a word moves when valid and ready are both high on a rising clk_i. A source must not withdraw valid or change data once it has asserted valid, until the word is accepted.
- State IDLE:
  - ser_valid_o=0.
  - If any req_valid_i is set, select the first set bit searching from rr+1 upward with wrap-around.
  - Register that selection into grant_o/active_chan_o and go to HEADER.
  - Arbitration latency is 1 cycle: valid at cycle t gives the header on ser_data_o at t+1.
- State HEADER:
  - ser_valid_o=1.
  - ser_data_o: bit DATA_WIDTH-1 = 1, bits [CHAN_W-1:0] = active_chan_o, all other bits 0.
  - All req_ready_o=0.
  - On ser_ready_i: beat counter=0, go to BURST.
- State BURST:
  - ser_data_o = granted requester's data.
  - ser_valid_o = granted req_valid_i.
  - req_ready_o[g] = ser_ready_i; all other ready bits are 0.
  - Payload words have bit DATA_WIDTH-1 unconstrained. Framing relies on the header position only.
  - On each transfer: if req_last_i[g], or beat counter == MAX_BURST-1, go to IDLE and set rr=g. Otherwise increment the beat counter.
  - Granted valid low: stall in BURST and hold the grant. There is no timeout.
- Truncation: burst_trunc_o pulses in the cycle of the ending transfer when beat counter == MAX_BURST-1 and last=0. The requester continues in a later grant, with a new header.
- A last flag coinciding with MAX_BURST is not a truncation.
- Back-to-back grants: IDLE always costs one bubble cycle between bursts.
- Fairness: a requester just served has lowest priority on the next arbitration. Requests that arrive while another channel holds the grant wait until IDLE.
- ser_ready_i low in HEADER: hold the header, grant is unchanged.
- Simultaneous requests in IDLE: round-robin order from rr+1 decides.
- A valid requester is never starved.

Test Plan:
- Reset, then req_valid_i=4'b0001 with 3 words (last on the 3rd), ser_ready_i=1 -> ser_data_o sequence 0x80,d0,d1,d2; req_ready_o[0] high for exactly 3 cycles; back to IDLE; grant_o=0.
- All 4 channels valid continuously, each sending 1-word messages (last=1) -> headers 0x80,0x81,0x82,0x83,0x80 in order; one IDLE bubble between bursts.
- Channel 2 sends 20 words with no last, MAX_BURST=8 -> bursts of 8, 8, 4 words, each preceded by header 0x82. burst_trunc_o pulses twice, on the 8th and 16th transfers.
- ser_ready_i toggles 1-0 during the header and payload -> no word is lost or duplicated; ser_data_o is stable while ser_valid_o=1 and ser_ready_i=0.
- Granted channel drops valid mid-burst for 5 cycles while channel 1 is valid -> grant held; no header for channel 1 until the granted burst's last transfer.
- rst_i asserted mid-burst, asynchronously with respect to clk_i -> outputs go to reset values immediately. The next arbitration starts from rr=NUM_REQ-1, so channel 0 wins if valid.
